pixel_ctrl: RTL and testbench

PIXEL_CTRL -- requirements
Module: pixel_ctrl

---
 rtl/pixel_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pixel_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_ctrl.sv
// Pixel-array sequencer: erase / expose / ramp-convert phases, then four-pixel readout stream.
// Optional build macro PIXEL_CTRL_GRAY_EN: Gray-coded ramp on the bus, decoded back at capture.
module pixel_ctrl #(
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       erase,
  output logic       expose,
  output logic       ramp,
  output logic       read0,
  output logic       read1,
  output logic       read2,
  output logic       read3,
  inout  wire  [7:0] data,
  output logic [7:0] pix_data,
  output logic [1:0] pix_idx,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRsel,
    StRcap,
    StRhold
  } state_t;

  localparam logic [7:0] EraseLast  = 8'(C_ERASE - 1);
  localparam logic [7:0] ExposeLast = 8'(C_EXPOSE - 1);
  localparam logic [7:0] ConvLast   = 8'(C_CONVERT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic [3:0] rd;
  logic       drv;

`ifdef PIXEL_CTRL_GRAY_EN
  function automatic logic [7:0] code(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [7:0] decode(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`else
  function automatic logic [7:0] code(input logic [7:0] v);
    return v;
  endfunction

  function automatic logic [7:0] decode(input logic [7:0] g);
    return g;
  endfunction
`endif

  // drv is cleared on the same edge that raises read0, so the bus is never shared.
  assign data  = drv ? code(cnt) : 8'hzz;
  assign read0 = rd[0];
  assign read1 = rd[1];
  assign read2 = rd[2];
  assign read3 = rd[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= '0;
      idx       <= '0;
      rd        <= '0;
      drv       <= 1'b0;
      erase     <= 1'b0;
      expose    <= 1'b0;
      ramp      <= 1'b0;
      pix_data  <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state <= StErase;
            cnt   <= '0;
            erase <= 1'b1;
            busy  <= 1'b1;
          end
        end
        StErase: begin
          if (cnt == EraseLast) begin
            state  <= StExpose;
            cnt    <= '0;
            erase  <= 1'b0;
            expose <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StExpose: begin
          if (cnt == ExposeLast) begin
            state  <= StConvert;
            cnt    <= '0;
            expose <= 1'b0;
            ramp   <= 1'b1;
            drv    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StConvert: begin
          if (cnt == ConvLast) begin
            state <= StRsel;
            cnt   <= '0;
            ramp  <= 1'b0;
            drv   <= 1'b0;
            idx   <= '0;
            rd    <= 4'b0001;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StRsel: begin
          state <= StRcap;
        end
        StRcap: begin
          pix_data  <= decode(data);
          pix_idx   <= idx;
          pix_valid <= 1'b1;
          state     <= StRhold;
        end
        StRhold: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (idx == 2'd3) begin
              state <= StIdle;
              idx   <= '0;
              rd    <= '0;
              busy  <= 1'b0;
            end else begin
              state <= StRsel;
              idx   <= idx + 2'd1;
              rd    <= 4'b0001 << (idx + 2'd1);
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_ctrl.sv
// Randomized self-checking bench for pixel_ctrl against a cycle-offset frame model.
module tb_pixel_ctrl;

  localparam int CE = 2;
  localparam int CX = 4;
  localparam int CC = 256;
  localparam int BASE_LAT = CE + CX + CC + 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pix_ready;
  logic       erase, expose, ramp;
  logic       read0, read1, read2, read3;
  logic [7:0] pix_data;
  logic [1:0] pix_idx;
  logic       pix_valid;
  logic       busy;
  wire  [7:0] data;

  logic [7:0] pix_val [4];
  logic [7:0] bus_word;
  logic [3:0] rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pixel_ctrl #(
    .C_ERASE  (CE),
    .C_EXPOSE (CX),
    .C_CONVERT(CC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .erase    (erase),
    .expose   (expose),
    .ramp     (ramp),
    .read0    (read0),
    .read1    (read1),
    .read2    (read2),
    .read3    (read3),
    .data     (data),
    .pix_data (pix_data),
    .pix_idx  (pix_idx),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy     (busy)
  );

  // Ramp code expected on the bus for a given step number.
  function automatic logic [7:0] code(input int n);
    logic [7:0] v;
    v = 8'(n);
`ifdef PIXEL_CTRL_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  assign rd = {read3, read2, read1, read0};

  // Pixel model: returns the encoded form of pix_val on the selected line.
  always_comb begin
    bus_word = 8'h00;
    if (read0) bus_word = code(int'(pix_val[0]));
    if (read1) bus_word = code(int'(pix_val[1]));
    if (read2) bus_word = code(int'(pix_val[2]));
    if (read3) bus_word = code(int'(pix_val[3]));
  end
  assign data = (rd != 4'b0000) ? bus_word : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(pix_valid), 32'd0);
    check("idle_ctrl", 32'({erase, expose, ramp}), 32'd0);
    check("idle_read", 32'(rd), 32'd0);
  endtask

  // One frame; pixel stall_idx is held off for stall_len cycles (stall_idx>=4: no stall).
  task automatic run_frame(input int stall_idx, input int stall_len, input bit chaos_start);
    int  c, xfers, stall_cnt, exp_lat, post_idx;
    bit  post;
    c = 0; xfers = 0; stall_cnt = 0; post = 1'b0; post_idx = 0;
    exp_lat = BASE_LAT + ((stall_idx < 4) ? stall_len : 0);
    @(negedge clk);
    start     = 1'b1;
    pix_ready = 1'($urandom);
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      c++;
      start = chaos_start ? 1'($urandom) : 1'b0;
      if (c > exp_lat + 50) begin
        check("frame_timeout", 32'(c), 32'(exp_lat));
        break;
      end
      if (post) begin
        check("post_valid", 32'(pix_valid), 32'd0);
        check("post_read", 32'(rd), 32'(4'b0001 << post_idx));
        post = 1'b0;
      end
      if (c <= CE + CX + CC) begin
        check("erase", 32'(erase), 32'(c <= CE));
        check("expose", 32'(expose), 32'(c > CE && c <= CE + CX));
        check("ramp", 32'(ramp), 32'(c > CE + CX));
        check("phase_read", 32'(rd), 32'd0);
        check("phase_valid", 32'(pix_valid), 32'd0);
        if (c > CE + CX) check("ramp_data", 32'(data), 32'(code(c - CE - CX - 1)));
        pix_ready = 1'($urandom);
      end else begin
        check("rd_ctrl", 32'({erase, expose, ramp}), 32'd0);
        check("rd_onehot", 32'($onehot(rd)), 32'd1);
        if (pix_valid) begin
          check("pix_idx", 32'(pix_idx), 32'(xfers & 3));
          check("pix_data", 32'(pix_data), 32'(pix_val[xfers & 3]));
          check("hold_read", 32'(rd), 32'(4'b0001 << (xfers & 3)));
          if (xfers == stall_idx && stall_cnt < stall_len) begin
            pix_ready = 1'b0;
            stall_cnt++;
          end else begin
            pix_ready = 1'b1;
            post      = (xfers < 3);
            post_idx  = xfers + 1;
            xfers++;
          end
        end else begin
          pix_ready = 1'($urandom);
        end
      end
    end
    start = 1'b0;
    check("latency", 32'(c), 32'(exp_lat));
    check("xfers", 32'(xfers), 32'd4);
    repeat (3) begin
      @(negedge clk);
      check_idle();
    end
  endtask

  task automatic randomize_pixels();
    for (int i = 0; i < 4; i++) pix_val[i] = 8'($urandom);
  endtask

  task automatic reset_mid_convert();
    int c;
    c = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < CE + CX + 101) begin
      @(negedge clk);
      c++;
    end
    check("pre_reset_ramp", 32'(ramp), 32'd1);
    check("pre_reset_data", 32'(data), 32'(code(100)));
    #2 reset = 1'b1;
    #1;
    check("rst_ramp", 32'(ramp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read", 32'(rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_valid", 32'(pix_valid), 32'd0);
    end
  endtask

  task automatic reset_in_rhold();
    int n;
    n = 0;
    @(negedge clk);
    start     = 1'b1;
    pix_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!pix_valid && n < BASE_LAT + 20) begin
      @(negedge clk);
      n++;
    end
    check("rhold_reached", 32'(pix_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rhold_rst_valid", 32'(pix_valid), 32'd0);
    check("rhold_rst_data", 32'(pix_data), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    pix_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("rhold_post_valid", 32'(pix_valid), 32'd0);
      check("rhold_post_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) pix_val[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_idle();
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_idx", 32'(pix_idx), 32'd0);
    reset = 1'b0;

    pix_val[0] = 8'h10; pix_val[1] = 8'h40; pix_val[2] = 8'h80; pix_val[3] = 8'hF0;
    run_frame(4, 0, 1'b0);

    randomize_pixels();
    pix_val[0] = 8'h05;
    run_frame(1, 10, 1'b1);

    for (int f = 0; f < 4; f++) begin
      randomize_pixels();
      run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b1);
    end

    reset_mid_convert();
    reset_in_rhold();

    randomize_pixels();
    run_frame(3, 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
